// File: rtl/sprite_move_ctrl.sv
// sprite_move_ctrl
// This module decodes PS/2 make codes into sprite move commands and queues
// them in a 4-entry FIFO. It applies at most one queued move per video frame,
// on the falling edge of vs. Position arithmetic uses 11 bits and clamps at the
// screen edges, so the sprite never wraps around.
module sprite_move_ctrl #(
  parameter int STEP   = 10,
  parameter int BOX_W  = 64,
  parameter int BOX_H  = 48,
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [7:0] key_in,
  input  logic       key_en,
  input  logic       vs,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       move_done,
  output logic       fifo_full,
  output logic       overflow
);

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] X_MAX  = 11'(H_ACT - BOX_W);
  localparam logic [10:0] Y_MAX  = 11'(V_ACT - BOX_H);

  localparam logic [1:0] CMD_UP    = 2'd0;
  localparam logic [1:0] CMD_DOWN  = 2'd1;
  localparam logic [1:0] CMD_LEFT  = 2'd2;
  localparam logic [1:0] CMD_RIGHT = 2'd3;

  typedef enum logic {S_MAKE, S_BREAK} decState_t;

  decState_t   decState_q;
  logic [1:0]  fifoMem_q [4];
  logic [1:0]  wrPtr_q, rdPtr_q;
  logic [2:0]  count_q, count_d;
  logic        vsD_q;
  logic [9:0]  posX_q, posY_q, posX_d, posY_d;
  logic        moveDone_q, overflow_q;

  logic        isCmd;
  logic [1:0]  cmdCode;
  logic        pushReq, pushEn, dropEn, popEn, tick;
  logic [1:0]  headCmd;
  logic [10:0] posX11, posY11, sumX11, sumY11;

  // Map the four arrow-key make codes onto 2-bit move commands.
  always_comb begin
    isCmd   = 1'b1;
    cmdCode = CMD_UP;
    case (key_in)
      8'h75:   cmdCode = CMD_UP;
      8'h72:   cmdCode = CMD_DOWN;
      8'h6B:   cmdCode = CMD_LEFT;
      8'h74:   cmdCode = CMD_RIGHT;
      default: isCmd = 1'b0;
    endcase
  end

  // A frame tick is a vs falling edge. The FIFO pops a command before it accepts
  // a push, so a full FIFO still takes a push in a cycle where it pops.
  always_comb begin
    tick    = vsD_q & ~vs;
    popEn   = tick && (count_q != 3'd0);
    pushReq = key_en && (decState_q == S_MAKE) && isCmd;
    pushEn  = pushReq && ((count_q != 3'd4) || popEn);
    dropEn  = pushReq && (count_q == 3'd4) && !popEn;
    count_d = count_q + {2'b00, pushEn} - {2'b00, popEn};
    headCmd = fifoMem_q[rdPtr_q];
  end

  // Compute the clamped next position for the command at the head of the FIFO.
  always_comb begin
    posX11 = {1'b0, posX_q};
    posY11 = {1'b0, posY_q};
    sumX11 = posX11 + STEP11;
    sumY11 = posY11 + STEP11;
    posX_d = posX_q;
    posY_d = posY_q;
    case (headCmd)
      CMD_UP:    posY_d = (posY11 >= STEP11) ? 10'(posY11 - STEP11) : 10'd0;
      CMD_DOWN:  posY_d = (sumY11 > Y_MAX) ? 10'(Y_MAX) : 10'(sumY11);
      CMD_LEFT:  posX_d = (posX11 >= STEP11) ? 10'(posX11 - STEP11) : 10'd0;
      default:   posX_d = (sumX11 > X_MAX) ? 10'(X_MAX) : 10'(sumX11);
    endcase
  end

  // Scan decoder FSM. E0 prefixes are ignored. After an F0, the next byte is a
  // key release and is swallowed.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      decState_q <= S_MAKE;
    end else if (key_en && (key_in != 8'hE0)) begin
      case (decState_q)
        S_MAKE:  if (key_in == 8'hF0) decState_q <= S_BREAK;
        default: decState_q <= S_MAKE;
      endcase
    end
  end

  // FIFO storage. It needs no reset because the pointers and count define validity.
  always_ff @(posedge vga_clk) begin
    if (pushEn) fifoMem_q[wrPtr_q] <= cmdCode;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= 2'd0;
      rdPtr_q    <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + 2'd1;
      if (popEn)  rdPtr_q <= rdPtr_q + 2'd1;
      count_q    <= count_d;
      overflow_q <= overflow_q | dropEn;
    end
  end

  // Frame-rate position update. vs_d resets high, so only a real vs fall ticks.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vsD_q      <= 1'b1;
      posX_q     <= 10'(X_INIT);
      posY_q     <= 10'(Y_INIT);
      moveDone_q <= 1'b0;
    end else begin
      vsD_q      <= vs;
      moveDone_q <= popEn;
      if (popEn) begin
        posX_q <= posX_d;
        posY_q <= posY_d;
      end
    end
  end

  assign pos_x     = posX_q;
  assign pos_y     = posY_q;
  assign move_done = moveDone_q;
  assign fifo_full = (count_q == 3'd4);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb_sprite_move_ctrl
// Scoreboard bench for sprite_move_ctrl. A reference model holds the command
// queue and the sprite position as plain integers. Each tick pushes the expected
// position onto a queue, and a monitor pops from it on every move_done.
module tb_sprite_move_ctrl;

  localparam int STEP   = 10;
  localparam int BOX_W  = 64;
  localparam int BOX_H  = 48;
  localparam int H_ACT  = 640;
  localparam int V_ACT  = 480;
  localparam int X_INIT = 320;
  localparam int Y_INIT = 240;

  logic       vgaClk = 1'b0;
  logic       reset;
  logic [7:0] keyIn;
  logic       keyEn;
  logic       vs;
  logic [9:0] posX, posY;
  logic       moveDone, fifoFull, overflow;

  typedef struct {
    int x;
    int y;
  } move_t;

  int    modelX, modelY;
  int    cmdQ[$];
  bit    breakPending;
  bit    modelOverflow;
  move_t expQ[$];
  int    compared   = 0;
  int    mismatched = 0;

  sprite_move_ctrl #(
    .STEP(STEP), .BOX_W(BOX_W), .BOX_H(BOX_H), .H_ACT(H_ACT), .V_ACT(V_ACT),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT)
  ) dut (
    .vga_clk  (vgaClk),
    .reset    (reset),
    .key_in   (keyIn),
    .key_en   (keyEn),
    .vs       (vs),
    .pos_x    (posX),
    .pos_y    (posY),
    .move_done(moveDone),
    .fifo_full(fifoFull),
    .overflow (overflow)
  );

  always #5 vgaClk = ~vgaClk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: a key byte as seen by the decoder.
  function automatic void modelKey(input logic [7:0] b);
    int code;
    if (b == 8'hE0) return;
    if (breakPending) begin
      breakPending = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      breakPending = 1'b1;
      return;
    end
    case (b)
      8'h75:   code = 0;
      8'h72:   code = 1;
      8'h6B:   code = 2;
      8'h74:   code = 3;
      default: code = -1;
    endcase
    if (code >= 0) begin
      if (cmdQ.size() < 4) cmdQ.push_back(code);
      else modelOverflow = 1'b1;
    end
  endfunction

  // Reference model: a frame tick applies the oldest command, if any.
  function automatic void modelTick();
    int    c;
    move_t m;
    if (cmdQ.size() == 0) return;
    c = cmdQ.pop_front();
    case (c)
      0:       modelY = (modelY >= STEP) ? modelY - STEP : 0;
      1:       modelY = (modelY + STEP > V_ACT - BOX_H) ? V_ACT - BOX_H : modelY + STEP;
      2:       modelX = (modelX >= STEP) ? modelX - STEP : 0;
      default: modelX = (modelX + STEP > H_ACT - BOX_W) ? H_ACT - BOX_W : modelX + STEP;
    endcase
    m.x = modelX;
    m.y = modelY;
    expQ.push_back(m);
  endfunction

  function automatic void modelReset();
    modelX        = X_INIT;
    modelY        = Y_INIT;
    cmdQ.delete();
    expQ.delete();
    breakPending  = 1'b0;
    modelOverflow = 1'b0;
  endfunction

  // Monitor: every move_done must match the next expected position.
  always @(negedge vgaClk) begin
    if (!reset && moveDone) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_move: move_done=1 with pos (%0d,%0d), expected no move (t=%0t)",
                 posX, posY, $time);
      end else begin
        move_t m;
        m = expQ.pop_front();
        checkOutput("move_pos_x", int'(posX), m.x);
        checkOutput("move_pos_y", int'(posY), m.y);
      end
    end
  end

  // One operation: an optional key strobe and an optional vs fall in the same cycle.
  task automatic applyStimulus(input bit doKey, input logic [7:0] b, input bit doTick);
    @(posedge vgaClk);
    #1;
    keyEn = doKey;
    keyIn = b;
    if (doTick) vs = 1'b0;
    if (doTick) modelTick();
    if (doKey)  modelKey(b);
    @(posedge vgaClk);
    #1;
    keyEn = 1'b0;
    if (doTick) begin
      repeat (2) @(posedge vgaClk);
      #1;
      vs = 1'b1;
      @(posedge vgaClk);
      #1;
    end
    @(negedge vgaClk);
    checkOutput("fifo_full", int'(fifoFull), (cmdQ.size() == 4) ? 1 : 0);
    checkOutput("overflow", int'(overflow), int'(modelOverflow));
    checkOutput("pending_moves", expQ.size(), 0);
    checkOutput("pos_x", int'(posX), modelX);
    checkOutput("pos_y", int'(posY), modelY);
  endtask

  task automatic sendKey(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0);
  endtask

  task automatic frameTick();
    applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  // Asynchronous reset pulse. Outputs are checked before any clock edge arrives.
  task automatic applyReset();
    @(posedge vgaClk);
    #2;
    keyEn = 1'b0;
    vs    = 1'b1;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_pos_x", int'(posX), X_INIT);
    checkOutput("rst_pos_y", int'(posY), Y_INIT);
    checkOutput("rst_move_done", int'(moveDone), 0);
    checkOutput("rst_fifo_full", int'(fifoFull), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    repeat (2) @(posedge vgaClk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] keyTable [6];
    keyTable = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0};
    reset = 1'b1;
    keyIn = 8'h00;
    keyEn = 1'b0;
    vs    = 1'b1;
    modelReset();
    #1;
    checkOutput("init_pos_x", int'(posX), X_INIT);
    checkOutput("init_pos_y", int'(posY), Y_INIT);
    checkOutput("init_fifo_full", int'(fifoFull), 0);
    checkOutput("init_overflow", int'(overflow), 0);
    repeat (2) @(posedge vgaClk);
    #1;
    reset = 1'b0;

    // One right move.
    sendKey(8'h74);
    frameTick();

    // The break code swallows the second up key.
    applyReset();
    sendKey(8'hE0); sendKey(8'h75); sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75);
    frameTick();
    frameTick();

    // Overfill the FIFO, then drain it with an extra empty tick.
    applyReset();
    repeat (6) sendKey(8'h6B);
    repeat (5) frameTick();

    // A push and a pop in the same cycle on a full FIFO.
    applyReset();
    repeat (4) sendKey(8'h72);
    applyStimulus(1'b1, 8'h74, 1'b1);
    repeat (5) frameTick();

    // Bottom clamp from 430.
    applyReset();
    repeat (19) begin sendKey(8'h72); frameTick(); end
    repeat (2)  begin sendKey(8'h72); frameTick(); end

    // Right clamp, then walk left past zero.
    applyReset();
    repeat (30) begin sendKey(8'h74); frameTick(); end
    repeat (59) begin sendKey(8'h6B); frameTick(); end

    // Reset discards queued commands.
    applyReset();
    sendKey(8'h75); sendKey(8'h72); sendKey(8'h74);
    frameTick();
    applyReset();
    repeat (3) frameTick();

    // Randomized mix of keys, garbage bytes and ticks.
    applyReset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5)      sendKey(keyTable[$urandom_range(0, 5)]);
      else if (r == 6) sendKey(8'($urandom));
      else if (r <= 8) frameTick();
      else             applyStimulus(1'b1, keyTable[$urandom_range(0, 3)], 1'b1);
    end

    repeat (4) @(posedge vgaClk);
    checkOutput("final_pending_moves", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
